// File: rtl/demux_one_cross_four_tdm_pkg.sv
// Shared constants and encodings for the 1-to-4 TDM demultiplexer.
// Channel index encoding matches the manual select {s0,s1}.
package demux_one_cross_four_tdm_pkg;

  localparam int NUM_CHAN = 4;
  localparam int CHAN_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [CHAN_W-1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } chan_e;

endpackage

// File: rtl/demux_one_cross_four_tdm_chan_counter.sv
// TDM channel counter: load-to-1 on a sync sample, clear on mode change,
// and a modulo-NUM_CHAN increment on each data sample.
module tdm_chan_counter
  import demux_one_cross_four_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_one,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [CHAN_W-1:0] o_chan
);

  logic [CHAN_W-1:0] r_chan;

  // A sync sample accepted in the same cycle as a mode change wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chan <= '0;
    end else if (i_load_one) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      r_chan <= CHAN_W'(1);
    end else if (i_clear) begin
      r_chan <= '0;
    end else if (i_inc) begin
      r_chan <= (r_chan == CHAN_W'(NUM_CHAN - 1)) ? '0 : r_chan + 1'b1;
    end
  end

  assign o_chan = r_chan;

endmodule

// File: rtl/demux_one_cross_four_tdm.sv
// 1-to-4 demultiplexer: TDM frame mode with staged, atomic output update,
// or manual mode with direct {s0,s1} addressing.
module demux_one_cross_four_tdm
  import demux_one_cross_four_tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  input  logic             manual,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       chan,
  output logic             frame_done,
  output logic             sync_err
);

  state_e            r_state;
  state_e            w_state_eff;
  state_e            w_state_next;
  logic              r_manual_q;
  logic              w_mode_chg;
  logic [CHAN_W-1:0] w_chan;
  logic [WIDTH-1:0]  r_stage [NUM_CHAN-1];
  logic [WIDTH-1:0]  r_a, r_b, r_c, r_d;
  logic              r_frame_done;
  logic              r_sync_err;

  logic w_sync_accept;
  logic w_data_accept;
  logic w_resync;
  logic w_frame_complete;
  logic w_manual_wr;

  // A mode flip behaves as if the FSM were already back in IDLE this cycle.
  assign w_mode_chg  = manual ^ r_manual_q;
  assign w_state_eff = w_mode_chg ? ST_IDLE : r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_manual_q <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_manual_q <= manual;
    end
  end

  always_comb begin
    w_state_next = w_state_eff;
    if (w_sync_accept) w_state_next = ST_RUN;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_sync_accept    = 1'b0;
    w_data_accept    = 1'b0;
    w_resync         = 1'b0;
    w_frame_complete = 1'b0;
    w_manual_wr      = 1'b0;
    if (manual) begin
      w_manual_wr = din_valid;
    end else if (din_valid) begin
      case (w_state_eff)
        ST_IDLE: w_sync_accept = frame_sync;
        ST_RUN: begin
          if (frame_sync) begin
            w_sync_accept = 1'b1;
            w_resync      = (w_chan != CH_A);
          end else begin
            w_data_accept    = 1'b1;
            w_frame_complete = (w_chan == CH_D);
          end
        end
        default: ;
      endcase
    end
  end

  tdm_chan_counter u_chan_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load_one (w_sync_accept),
    .i_clear    (w_mode_chg),
    .i_inc      (w_data_accept),
    .o_chan     (w_chan)
  );

  // Slot 3 is never staged: it goes straight to D with the rest of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: staging is a handful of flops, so it is reset like any other state.
      for (int i = 0; i < NUM_CHAN - 1; i++) r_stage[i] <= '0;
    end else begin
      if (w_mode_chg || w_resync) begin
        for (int i = 0; i < NUM_CHAN - 1; i++) r_stage[i] <= '0;
      end
      if (w_sync_accept) begin
        r_stage[0] <= din;
      end else if (w_data_accept) begin
        for (int i = 0; i < NUM_CHAN - 1; i++) begin
          if (w_chan == CHAN_W'(i)) r_stage[i] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_d          <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_frame_done <= w_frame_complete;
      r_sync_err   <= w_resync;
      if (w_frame_complete) begin
        r_a <= r_stage[0];
        r_b <= r_stage[1];
        r_c <= r_stage[2];
        r_d <= din;
      end else if (w_manual_wr) begin
        case ({s0, s1})
          CH_A:    r_a <= din;
          CH_B:    r_b <= din;
          CH_C:    r_c <= din;
          default: r_d <= din;
        endcase
      end
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign C          = r_c;
  assign D          = r_d;
  assign chan       = w_chan;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_demux_one_cross_four_tdm.sv
// Directed bench for demux_one_cross_four_tdm at WIDTH=4: frame mode, resync,
// gaps, manual addressing, async reset and mode switching.
module tb_demux_one_cross_four_tdm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       manual = 1'b0;
  logic       s0 = 1'b0;
  logic       s1 = 1'b0;
  logic [3:0] A, B, C, D;
  logic [1:0] chan;
  logic       frame_done;
  logic       sync_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_one_cross_four_tdm #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .manual     (manual),
    .s0         (s0),
    .s1         (s1),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .chan       (chan),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // Apply one cycle of stimulus at the falling edge; return 1 time unit after
  // the rising edge that consumed it.
  task automatic cycle(input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({A, B, C, D} !== 16'h0000) begin
      n_errors++; $display("FAIL reset_out: got %h exp 0000", {A, B, C, D});
    end
    n_checks++;
    if ({chan, frame_done, sync_err} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_ctl: chan/fd/se got %b exp 0000", {chan, frame_done, sync_err});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    cycle(1, 1, 4'd1);
    n_checks++;
    if ({A, B, C, D, chan} !== {16'h0000, 2'd1}) begin
      n_errors++; $display("FAIL frame_s0: out %h chan %0d exp 0000 chan 1", {A, B, C, D}, chan);
    end
    cycle(1, 0, 4'd2);
    cycle(1, 0, 4'd3);
    n_checks++;
    if ({A, B, C, D, chan, frame_done} !== {16'h0000, 2'd3, 1'b0}) begin
      n_errors++; $display("FAIL frame_partial: out %h chan %0d fd %b exp 0000 chan 3 fd 0", {A, B, C, D}, chan, frame_done);
    end
    cycle(1, 0, 4'd4);
    n_checks++;
    if ({A, B, C, D, chan, frame_done} !== {16'h1234, 2'd0, 1'b1}) begin
      n_errors++; $display("FAIL frame_done: out %h chan %0d fd %b exp 1234 chan 0 fd 1", {A, B, C, D}, chan, frame_done);
    end
    cycle(0, 0, 4'd0);
    n_checks++;
    if ({A, B, C, D, frame_done} !== {16'h1234, 1'b0}) begin
      n_errors++; $display("FAIL frame_pulse: out %h fd %b exp 1234 fd 0", {A, B, C, D}, frame_done);
    end
  endtask

  task automatic test_resync();
    cycle(1, 1, 4'd5);
    cycle(1, 0, 4'd6);
    cycle(1, 1, 4'd7);
    n_checks++;
    if ({A, B, C, D, chan, sync_err} !== {16'h1234, 2'd1, 1'b1}) begin
      n_errors++; $display("FAIL resync_err: out %h chan %0d se %b exp 1234 chan 1 se 1", {A, B, C, D}, chan, sync_err);
    end
    cycle(1, 0, 4'd8);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_errors++; $display("FAIL resync_pulse: se got %b exp 0", sync_err);
    end
    cycle(1, 0, 4'd9);
    n_checks++;
    if ({A, B, C, D} !== 16'h1234) begin
      n_errors++; $display("FAIL resync_hold: got %h exp 1234", {A, B, C, D});
    end
    cycle(1, 0, 4'd10);
    n_checks++;
    if ({A, B, C, D, frame_done, sync_err} !== {16'h789A, 2'b10}) begin
      n_errors++; $display("FAIL resync_frame: out %h fd %b se %b exp 789a fd 1 se 0", {A, B, C, D}, frame_done, sync_err);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 1, 4'd1);
    n_checks++;
    if ({chan, sync_err} !== {2'd1, 1'b0}) begin
      n_errors++; $display("FAIL b2b_sync0: chan %0d se %b exp chan 1 se 0", chan, sync_err);
    end
    cycle(1, 0, 4'd2);
    cycle(1, 0, 4'd3);
    cycle(1, 0, 4'd4);
    cycle(1, 1, 4'd5);
    n_checks++;
    if ({A, B, C, D, frame_done, sync_err} !== {16'h1234, 2'b00}) begin
      n_errors++; $display("FAIL b2b_first: out %h fd %b se %b exp 1234 fd 0 se 0", {A, B, C, D}, frame_done, sync_err);
    end
    cycle(1, 0, 4'd6);
    cycle(1, 0, 4'd7);
    cycle(1, 0, 4'd8);
    n_checks++;
    if ({A, B, C, D, frame_done} !== {16'h5678, 1'b1}) begin
      n_errors++; $display("FAIL b2b_second: out %h fd %b exp 5678 fd 1", {A, B, C, D}, frame_done);
    end
    // Chan wrapped to 0 while in RUN: slot 0 may arrive without frame_sync.
    cycle(1, 0, 4'd9);
    cycle(1, 0, 4'd10);
    cycle(1, 0, 4'd11);
    cycle(1, 0, 4'd12);
    n_checks++;
    if ({A, B, C, D, frame_done, sync_err} !== {16'h9ABC, 2'b10}) begin
      n_errors++; $display("FAIL b2b_nosync: out %h fd %b se %b exp 9abc fd 1 se 0", {A, B, C, D}, frame_done, sync_err);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    cycle(1, 0, 4'hF);
    n_checks++;
    if ({A, B, C, D, chan} !== {16'h0000, 2'd0}) begin
      n_errors++; $display("FAIL gaps_idle: out %h chan %0d exp 0000 chan 0", {A, B, C, D}, chan);
    end
    cycle(1, 1, 4'd1);
    cycle(0, 0, 4'd0);
    cycle(0, 1, 4'd7);
    n_checks++;
    if ({chan, sync_err} !== {2'd1, 1'b0}) begin
      n_errors++; $display("FAIL gaps_hold1: chan %0d se %b exp chan 1 se 0", chan, sync_err);
    end
    cycle(1, 0, 4'd2);
    cycle(0, 0, 4'd0);
    cycle(0, 0, 4'd0);
    n_checks++;
    if (chan !== 2'd2) begin
      n_errors++; $display("FAIL gaps_hold2: chan %0d exp 2", chan);
    end
    cycle(1, 0, 4'd3);
    cycle(1, 0, 4'd4);
    n_checks++;
    if ({A, B, C, D, chan} !== {16'h1234, 2'd0}) begin
      n_errors++; $display("FAIL gaps_frame: out %h chan %0d exp 1234 chan 0", {A, B, C, D}, chan);
    end
  endtask

  task automatic test_manual();
    manual = 1'b1; s0 = 1'b1; s1 = 1'b0;
    cycle(1, 0, 4'hA);
    n_checks++;
    if ({A, B, C, D, frame_done, chan} !== {16'h12A4, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL manual_c: out %h fd %b chan %0d exp 12a4 fd 0 chan 0", {A, B, C, D}, frame_done, chan);
    end
    s0 = 1'b1; s1 = 1'b1;
    cycle(1, 1, 4'd5);
    n_checks++;
    if ({A, B, C, D, frame_done, sync_err} !== {16'h12A5, 2'b00}) begin
      n_errors++; $display("FAIL manual_d: out %h fd %b se %b exp 12a5 fd 0 se 0", {A, B, C, D}, frame_done, sync_err);
    end
    s0 = 1'b0; s1 = 1'b0;
    cycle(0, 0, 4'd7);
    n_checks++;
    if ({A, B, C, D} !== 16'h12A5) begin
      n_errors++; $display("FAIL manual_novalid: got %h exp 12a5", {A, B, C, D});
    end
  endtask

  task automatic test_async_reset();
    manual = 1'b0;
    cycle(1, 1, 4'd1);
    cycle(1, 0, 4'd2);
    n_checks++;
    if (chan !== 2'd2) begin
      n_errors++; $display("FAIL areset_pre: chan %0d exp 2", chan);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({A, B, C, D, chan, frame_done, sync_err} !== 20'h0) begin
      n_errors++; $display("FAIL areset_now: out %h chan %0d fd %b se %b exp all 0", {A, B, C, D}, chan, frame_done, sync_err);
    end
    #3 rst = 1'b0;
    cycle(1, 0, 4'd3);
    cycle(1, 0, 4'd4);
    n_checks++;
    if ({A, B, C, D, chan} !== {16'h0000, 2'd0}) begin
      n_errors++; $display("FAIL areset_nosync: out %h chan %0d exp 0000 chan 0", {A, B, C, D}, chan);
    end
  endtask

  task automatic test_mode_switch();
    cycle(1, 1, 4'd1);
    cycle(1, 0, 4'd2);
    manual = 1'b1; s0 = 1'b0; s1 = 1'b0;
    cycle(1, 0, 4'd9);
    n_checks++;
    if ({A, B, C, D, chan, frame_done} !== {16'h9000, 2'd0, 1'b0}) begin
      n_errors++; $display("FAIL mswitch_manual: out %h chan %0d fd %b exp 9000 chan 0 fd 0", {A, B, C, D}, chan, frame_done);
    end
    manual = 1'b0;
    cycle(1, 0, 4'd3);
    cycle(1, 0, 4'd4);
    n_checks++;
    if ({A, B, C, D, chan} !== {16'h9000, 2'd0}) begin
      n_errors++; $display("FAIL mswitch_nosync: out %h chan %0d exp 9000 chan 0", {A, B, C, D}, chan);
    end
    cycle(1, 1, 4'd5);
    cycle(1, 0, 4'd6);
    cycle(1, 0, 4'd7);
    cycle(1, 0, 4'd8);
    n_checks++;
    if ({A, B, C, D, frame_done} !== {16'h5678, 1'b1}) begin
      n_errors++; $display("FAIL mswitch_frame: out %h fd %b exp 5678 fd 1", {A, B, C, D}, frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_resync();
    test_back_to_back();
    test_gaps();
    test_manual();
    test_async_reset();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_one_cross_four_tdm.md
DEMUX_ONE_CROSS_FOUR_TDM -- requirements
Module: demux_one_cross_four_tdm

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of din and of each output channel.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port din, input, WIDTH: time-multiplexed sample.
REQ-005 SHALL have port din_valid, input, 1: din holds a sample this cycle.
REQ-006 SHALL have port frame_sync, input, 1: sample on din is channel 0 (A) of a frame.
REQ-007 SHALL have port manual, input, 1: 1 selects direct addressing by s0/s1; 0 selects TDM frame mode.
REQ-008 SHALL have ports s0, s1, input, 1 each: manual channel index {s0,s1}: 00=A, 01=B, 10=C, 11=D.
REQ-009 SHALL have ports A, B, C, D, output, WIDTH each: registered demultiplexed channel outputs.
REQ-010 SHALL have port chan, output, 2: next TDM channel index expected.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse when A..D update from a full frame.
REQ-012 SHALL have port sync_err, output, 1: one-cycle pulse on mid-frame resync.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; the FSM is used only when manual=0.
REQ-014 IDLE: samples without frame_sync SHALL be discarded; din_valid&frame_sync SHALL store din in staging slot 0, set chan=1, go RUN.
REQ-015 RUN: din_valid&!frame_sync SHALL store din in staging slot chan and increment chan modulo 4.
REQ-016 On accepting the slot-3 sample, A..D SHALL load staging slots 0..2 plus that sample together at the same clock edge; frame_done SHALL pulse in that same cycle (registered, visible the cycle after acceptance); chan SHALL wrap to 0; FSM SHALL stay RUN.
REQ-017 RUN with chan=0: din_valid&frame_sync SHALL be a normal slot-0 accept, with no error.
REQ-018 RUN with chan!=0: din_valid&frame_sync SHALL discard partial staging, store din in slot 0, set chan=1, and pulse sync_err; A..D SHALL be unchanged.
REQ-019 frame_sync without din_valid SHALL be ignored in all states.
REQ-020 A..D SHALL change in frame mode only on a complete frame; partial frames SHALL never reach outputs.
REQ-021 manual=1: din_valid SHALL write din to the output selected by {s0,s1} at the next edge; other outputs SHALL hold; frame_done and sync_err SHALL stay 0.
REQ-022 Any change of manual (either direction) SHALL force IDLE, chan=0, and discard staging; a sample accepted in that cycle SHALL follow the new mode.
REQ-023 Latency din_valid to output update SHALL be 1 cycle (manual, or slot-3 sample).
REQ-024 din_valid=0 cycles between samples SHALL NOT advance chan or disturb staging.

Reset
REQ-025 rst=1 SHALL immediately force A=B=C=D=0, staging=0, chan=0, FSM=IDLE, frame_done=0, sync_err=0, regardless of clk.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL require frame_sync.

Structure
REQ-027 Shared package SHALL hold channel count (4), FSM state encoding (IDLE, RUN), and the 2-bit channel index encoding A=0..D=3.
REQ-028 The channel counter with wrap, load-to-1 and clear SHALL be the sub-module tdm_chan_counter; all other logic SHALL be in demux_one_cross_four_tdm.

Verification
REQ-029 Frame mode, WIDTH=4: samples 1(sync),2,3,4 on consecutive cycles -> A=1,B=2,C=3,D=4, all updated in the same cycle, frame_done high for exactly 1 cycle, chan=0.
REQ-030 Resync: 5(sync),6, then 7(sync),8,9,10 -> sync_err pulse on the 7 cycle, A..D unchanged until the final sample, then A=7,B=8,C=9,D=10.
REQ-031 Gaps and no sync: 0xF without sync in IDLE -> ignored; frame 1(sync),idle,2,idle,idle,3,4 -> A..D=1,2,3,4, chan holds during gaps.
REQ-032 Manual: manual=1, {s0,s1}=10, din=0xA valid -> C=0xA next cycle, A,B,D held, frame_done=0.
REQ-033 Reset mid-frame: after 1(sync),2, assert rst asynchronously (not clock-aligned) -> outputs 0 immediately; after release, 3 without sync is ignored.
REQ-034 Mode switch mid-frame: 1(sync),2, then manual=1 with 00/din=9 -> A=9, staging discarded; back to manual=0 requires frame_sync.
